// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg
//   Shared definitions for the programmable serial pattern scanner.
//   - ST_* : controller state encodings (IDLE, ARM, SCAN, DONE)
//   - len_w(): width of a pattern-length field able to hold 0..pat_w
package seq_scan_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core
//   History shift register, bits-seen counter and masked pattern compare.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : clear history and bits-seen
//     shift_en   : shift x into the history this cycle
//     x          : serial data bit
//     len        : pattern length (1..PAT_W while scanning)
//     pattern    : pattern, bit 0 = most recent bit
//     hit        : combinational; the bit being shifted in completes a match
//   Build option: SEQ_SCAN_NONOVERLAP_EN clears bits-seen on every match so
//   the next match needs len fresh bits.
module seq_match_core
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             x,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] seen;
    logic [LEN_W-1:0] seen_nxt;

    // The truncating cast drops the oldest bit and also works for PAT_W == 1.
    assign hist_nxt = PAT_W'({hist, x});
    assign seen_nxt = (seen < len) ? seen + LEN_W'(1) : seen;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Compare against the post-shift view so the match is flagged in the same
    // cycle the completing bit is accepted.
    assign hit = shift_en && (seen_nxt >= len) &&
                 (((hist_nxt ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            seen <= '0;
        end else if (clr) begin
            hist <= '0;
            seen <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
`ifdef SEQ_SCAN_NONOVERLAP_EN
            seen <= hit ? '0 : seen_nxt;
`else
            seen <= seen_nxt;
`endif
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Sequences a programmable serial pattern matcher over a window of
//   cfg_window accepted bits and returns the match count.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start               : begin a scan (IDLE only)
//     cfg_pattern/len/window : scan configuration, latched on start
//     x, x_valid          : serial bit and its qualifier (SCAN only)
//     busy                : controller not idle
//     match               : registered one-cycle pulse per match
//     res_valid/res_ready : result handshake
//     res_count/sat/err   : match count, counter saturated, illegal length
//     dbg_state           : current controller state (ST_* encoding)
//   Build option: SEQ_SCAN_NONOVERLAP_EN selects non-overlapping matching.
//
// Handshake: res_valid is high for the whole of DONE and the result fields are
// frozen there; the transfer happens on an edge where res_valid & res_ready,
// and the controller is IDLE from that edge.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [len_w(PAT_W)-1:0]  cfg_len,
    input  logic [WIN_W-1:0]         cfg_window,
    input  logic                     x,
    input  logic                     x_valid,
    output logic                     busy,
    output logic                     match,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CNT_W-1:0]         res_count,
    output logic                     res_sat,
    output logic                     res_err,
    output logic [1:0]               dbg_state
);

    localparam int LEN_W = len_w(PAT_W);

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             err_q;
    logic             match_q;
    logic             accept;
    logic             hit;
    logic             len_bad;

    assign accept  = (state == ST_SCAN) && x_valid;
    assign win_nxt = win_cnt + WIN_W'(1);
    assign len_bad = (cfg_len == '0) || (int'(cfg_len) > PAT_W);

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ST_ARM),
        .shift_en (accept),
        .x        (x),
        .len      (len_q),
        .pattern  (pat_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            win_q   <= '0;
            win_cnt <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= accept && hit;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        win_q <= cfg_window;
                        cnt_q <= '0;
                        sat_q <= 1'b0;
                        err_q <= len_bad;
                        // An unusable length skips the scan entirely.
                        state <= len_bad ? ST_DONE : ST_ARM;
                    end
                end
                ST_ARM: begin
                    win_cnt <= '0;
                    cnt_q   <= '0;
                    sat_q   <= 1'b0;
                    state   <= (win_q == '0) ? ST_DONE : ST_SCAN;
                end
                ST_SCAN: begin
                    if (x_valid) begin
                        win_cnt <= win_nxt;
                        if (hit) begin
                            if (cnt_q == {CNT_W{1'b1}}) begin
                                sat_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        if (win_nxt == win_q) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign match     = match_q;
    assign res_valid = (state == ST_DONE);
    assign res_count = cnt_q;
    assign res_sat   = sat_q;
    assign res_err   = err_q;
    assign dbg_state = state;

endmodule
